// File: rtl/edge_capture_scheduler_if.sv
// Bus bundle between the edge capture scheduler and its controller.
// The master drives capture/pop/clear controls; the slave returns FIFO head and status.
interface edge_capture_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
);
  localparam int CH_W = $clog2(WIDTH);
  localparam int LW   = $clog2(DEPTH) + 1;

  logic             enable;
  logic [WIDTH-1:0] edge_detected;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic [WIDTH-1:0] overrun_clr;

  logic             fifo_valid;
  logic [CH_W-1:0]  fifo_chan;
  logic [CNT_W-1:0] fifo_stamp;
  logic [LW-1:0]    fifo_level;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] overrun;
  logic             irq;

  modport master (
    output enable, edge_detected, count, pop, overrun_clr,
    input  fifo_valid, fifo_chan, fifo_stamp, fifo_level, pending, overrun, irq
  );

  modport slave (
    input  enable, edge_detected, count, pop, overrun_clr,
    output fifo_valid, fifo_chan, fifo_stamp, fifo_level, pending, overrun, irq
  );
endinterface

// File: rtl/edge_capture_scheduler.sv
// Input-capture scheduler: per-channel timestamp latches, round-robin arbiter
// and a shared first-word-fall-through FIFO of {channel, timestamp} records.
module edge_capture_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    n_rst,
  edge_capture_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(WIDTH);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;

  logic [WIDTH-1:0] pending, overrun;
  logic [CNT_W-1:0] stamp [WIDTH];
  logic [CH_W-1:0]  ptr;

  logic [CH_W-1:0]  mem_chan  [DEPTH];
  logic [CNT_W-1:0] mem_stamp [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;

  logic             fifo_empty, fifo_full, can_accept, push, pop_eff;
  logic             grant_valid;
  logic [CH_W-1:0]  grant_idx, cand, ptr_next;
  logic [WIDTH-1:0] grant_oh, edge_en, capture, ovr_set;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));
  assign pop_eff    = bus.pop & ~fifo_empty;
  // A full FIFO still takes a push when the head is popped in the same cycle.
  assign can_accept = ~fifo_full | bus.pop;

  // Scan downward from ptr+WIDTH-1 to ptr so the last hit is the first pending
  // channel at or after ptr.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      // NOTE: blocking assignments here; cand is a scratch value reused per iteration.
      cand = CH_W'((int'(ptr) + k) % WIDTH);
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign push     = can_accept & grant_valid;
  assign grant_oh = push ? (WIDTH'(1) << grant_idx) : '0;
  assign ptr_next = (grant_idx == CH_W'(WIDTH - 1)) ? '0 : grant_idx + 1'b1;

  // A channel being granted this cycle is free to take a fresh capture.
  assign edge_en = bus.edge_detected & {WIDTH{bus.enable}};
  assign capture = edge_en & (~pending | grant_oh);
  assign ovr_set = edge_en & pending & ~grant_oh;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending <= '0;
      overrun <= '0;
      ptr     <= '0;
      // NOTE: the stamp latches are visible state and are cleared; FIFO storage
      // below is not, because its outputs are masked while the FIFO is empty.
      for (int i = 0; i < WIDTH; i++) stamp[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      pending <= (pending & ~grant_oh) | capture;
      overrun <= (overrun & ~bus.overrun_clr) | ovr_set;
      if (push) ptr <= ptr_next;
      for (int i = 0; i < WIDTH; i++) begin
        if (capture[i]) stamp[i] <= bus.count;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_chan[wr_ptr]  <= grant_idx;
      mem_stamp[wr_ptr] <= stamp[grant_idx];
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_eff})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bus.fifo_valid = ~fifo_empty;
  assign bus.fifo_chan  = fifo_empty ? '0 : mem_chan[rd_ptr];
  assign bus.fifo_stamp = fifo_empty ? '0 : mem_stamp[rd_ptr];
  assign bus.fifo_level = level;
  assign bus.pending    = pending;
  assign bus.overrun    = overrun;
  assign bus.irq        = ~fifo_empty | (|overrun);
endmodule

// File: tb/tb_edge_capture_scheduler.sv
// Directed scenarios plus randomized traffic for edge_capture_scheduler, checked
// cycle by cycle against a queue-based reference model.
module tb_edge_capture_scheduler;
  localparam int WIDTH = 8;
  localparam int CNT_W = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic n_rst;

  edge_capture_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

  edge_capture_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               ch;
    logic [CNT_W-1:0] st;
  } rec_t;

  rec_t             m_q[$];
  bit               m_pend [WIDTH];
  bit               m_ovr  [WIDTH];
  logic [CNT_W-1:0] m_stamp[WIDTH];
  int               m_ptr;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ptr = 0;
    for (int i = 0; i < WIDTH; i++) begin
      m_pend[i]  = 1'b0;
      m_ovr[i]   = 1'b0;
      m_stamp[i] = '0;
    end
  endtask

  // One clock edge of the reference behaviour, using the pre-edge state.
  task automatic model_step(input bit en, input logic [WIDTH-1:0] e,
                            input logic [CNT_W-1:0] c, input bit p,
                            input logic [WIDTH-1:0] clr);
    int   g;
    rec_t r;
    bit   set;
    g = -1;
    r.ch = 0;
    r.st = '0;
    if (m_q.size() < DEPTH || p) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % WIDTH]) g = (m_ptr + k) % WIDTH;
      end
    end
    if (g >= 0) begin
      r.ch      = g;
      r.st      = m_stamp[g];
      m_pend[g] = 1'b0;
      m_ptr     = (g + 1) % WIDTH;
    end
    if (p && m_q.size() > 0) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(r);
    for (int i = 0; i < WIDTH; i++) begin
      set = 1'b0;
      if (en && e[i]) begin
        if (!m_pend[i]) begin
          m_stamp[i] = c;
          m_pend[i]  = 1'b1;
        end else begin
          set = 1'b1;
        end
      end
      m_ovr[i] = (m_ovr[i] && !clr[i]) || set;
    end
  endtask

  function automatic logic [WIDTH-1:0] vec_of(input bit b[WIDTH]);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = b[i];
    return v;
  endfunction

  task automatic compare_all();
    logic [WIDTH-1:0] ov;
    bit               nonempty;
    ov       = vec_of(m_ovr);
    nonempty = (m_q.size() != 0);
    check("fifo_valid", 64'(bus.fifo_valid), 64'(nonempty));
    check("fifo_chan",  64'(bus.fifo_chan),  nonempty ? 64'(m_q[0].ch) : 64'd0);
    check("fifo_stamp", 64'(bus.fifo_stamp), nonempty ? 64'(m_q[0].st) : 64'd0);
    check("fifo_level", 64'(bus.fifo_level), 64'(m_q.size()));
    check("pending",    64'(bus.pending),    64'(vec_of(m_pend)));
    check("overrun",    64'(bus.overrun),    64'(ov));
    check("irq",        64'(bus.irq),        64'(nonempty || (ov != '0)));
  endtask

  task automatic step(input bit en, input logic [WIDTH-1:0] e,
                      input logic [CNT_W-1:0] c, input bit p,
                      input logic [WIDTH-1:0] clr);
    bus.enable        = en;
    bus.edge_detected = e;
    bus.count         = c;
    bus.pop           = p;
    bus.overrun_clr   = clr;
    @(posedge clk);
    model_step(en, e, c, p, clr);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 32'h0, 1'b0, '0);
  endtask

  task automatic pop_once();
    step(1'b1, '0, 32'h0, 1'b1, '0);
  endtask

  task automatic do_reset();
    bus.enable        = 1'b0;
    bus.edge_detected = '0;
    bus.count         = '0;
    bus.pop           = 1'b0;
    bus.overrun_clr   = '0;
    n_rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  int order[3] = '{1, 3, 7};

  initial begin
    n_rst = 1'b1;
    #3;
    phase = "reset";
    do_reset();

    phase = "single";
    step(1'b1, 8'h04, 32'h100, 1'b0, '0);
    check("latency_t1_valid", 64'(bus.fifo_valid), 64'd0);
    step(1'b1, '0, 32'h101, 1'b0, '0);
    check("se_valid", 64'(bus.fifo_valid), 64'd1);
    check("se_chan",  64'(bus.fifo_chan),  64'd2);
    check("se_stamp", 64'(bus.fifo_stamp), 64'h100);
    check("se_level", 64'(bus.fifo_level), 64'd1);
    check("se_irq",   64'(bus.irq),        64'd1);
    pop_once();
    check("se_pop_valid", 64'(bus.fifo_valid), 64'd0);
    check("se_pop_irq",   64'(bus.irq),        64'd0);

    phase = "round_robin";
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      step(1'b1, 8'h8A, 32'h50, 1'b0, '0);
      idle(3);
      check("rr_level", 64'(bus.fifo_level), 64'd3);
      for (int j = 0; j < 3; j++) begin
        check("rr_chan",  64'(bus.fifo_chan),  64'(order[j]));
        check("rr_stamp", 64'(bus.fifo_stamp), 64'h50);
        pop_once();
      end
    end

    phase = "full";
    do_reset();
    step(1'b1, 8'h1F, 32'h10, 1'b0, '0);
    idle(5);
    check("full_level",   64'(bus.fifo_level), 64'd4);
    check("full_pending", 64'(bus.pending),    64'h10);
    step(1'b1, 8'h10, 32'h20, 1'b0, '0);
    check("full_overrun", 64'(bus.overrun), 64'h10);
    check("full_irq",     64'(bus.irq),     64'd1);
    pop_once();
    check("full_pop_level",   64'(bus.fifo_level), 64'd4);
    check("full_pop_pending", 64'(bus.pending),    64'h00);
    step(1'b1, '0, 32'h21, 1'b0, 8'h10);
    check("full_clr", 64'(bus.overrun), 64'h00);
    step(1'b1, 8'h10, 32'h30, 1'b0, '0);
    step(1'b1, 8'h10, 32'h31, 1'b0, 8'h10);
    check("full_set_wins", 64'(bus.overrun), 64'h10);
    for (int j = 0; j < 6; j++) pop_once();
    check("full_drained", 64'(bus.fifo_level), 64'd0);

    phase = "collision";
    do_reset();
    step(1'b1, 8'h20, 32'h180, 1'b0, '0);
    step(1'b1, 8'h20, 32'h200, 1'b0, '0);
    check("col_stamp",   64'(bus.fifo_stamp), 64'h180);
    check("col_pending", 64'(bus.pending),    64'h20);
    check("col_overrun", 64'(bus.overrun),    64'h00);
    idle(1);
    pop_once();
    check("col_next_stamp", 64'(bus.fifo_stamp), 64'h200);
    check("col_next_chan",  64'(bus.fifo_chan),  64'd5);

    phase = "disable";
    do_reset();
    step(1'b1, 8'h3F, 32'h400, 1'b0, '0);
    idle(4);
    step(1'b0, 8'hFF, 32'h401, 1'b0, '0);
    check("dis_pending", 64'(bus.pending), 64'h30);
    check("dis_overrun", 64'(bus.overrun), 64'h00);
    for (int j = 0; j < 6; j++) step(1'b0, 8'hFF, 32'h402, 1'b1, '0);
    check("dis_level",   64'(bus.fifo_level), 64'd0);
    check("dis_pend_0",  64'(bus.pending),    64'h00);

    phase = "mid_reset";
    do_reset();
    step(1'b1, 8'h0F, 32'h600, 1'b0, '0);
    step(1'b1, 8'h02, 32'h601, 1'b0, '0);
    check("mr_overrun_pre", 64'(bus.overrun), 64'h02);
    #2;
    do_reset();
    check("mr_irq",   64'(bus.irq),        64'd0);
    check("mr_level", 64'(bus.fifo_level), 64'd0);
    step(1'b1, 8'h01, 32'h700, 1'b0, '0);
    idle(1);
    check("mr_chan",  64'(bus.fifo_chan),  64'd0);
    check("mr_stamp", 64'(bus.fifo_stamp), 64'h700);

    phase = "random";
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) != 0,
           WIDTH'($urandom & $urandom & $urandom),
           CNT_W'($urandom),
           $urandom_range(0, 2) == 0,
           ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
